// File: rtl/decode_stage.sv
// Decode stage: one instruction in, one decoded bundle out, latency 1 cycle.
// Output register plus skid register; in_ready is the registered "skid empty" flag.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int BE_W     = XLEN / 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_mem_read,
  output logic [1:0]      out_rf_src,
  output logic            out_alu_src,
  output logic [BE_W-1:0] out_we,
  output logic [BE_W-1:0] out_reg_write,
  output logic [XLEN-1:0] out_imm,
  output logic            out_sign,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            branch;
    logic            jump;
    logic            mem_read;
    logic [1:0]      rf_src;
    logic            alu_src;
    logic [BE_W-1:0] we;
    logic [BE_W-1:0] reg_write;
    logic [XLEN-1:0] imm;
    logic            sign;
    logic            illegal;
  } bundle_t;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;

  bundle_t dec;
  bundle_t out_q, out_d, skid_q, skid_d;
  logic    out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic    accept, drain;

  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [7:0]      size_m8;
  logic [BE_W-1:0] size_mask;
  logic [BE_W-1:0] full_mask;
  logic            size_bad;
  logic            bad;

  assign opcode = in_instr[6:2];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};

  assign full_mask = '1;

  // Access size from funct3[1:0]; doubleword only exists on a 64-bit datapath.
  always_comb begin
    case (funct3[1:0])
      2'b00:   size_m8 = 8'h01;
      2'b01:   size_m8 = 8'h03;
      2'b10:   size_m8 = 8'h0F;
      default: size_m8 = 8'hFF;
    endcase
  end
  assign size_mask = size_m8[BE_W-1:0];
  assign size_bad  = (funct3[1:0] == 2'b11) && (XLEN == 32);

  always_comb begin
    dec    = '0;
    bad    = 1'b0;
    dec.pc = in_pc;
    if (in_instr[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (opcode)
        OP_LUI: begin
          dec.rf_src    = 2'b00;
          dec.alu_src   = 1'b1;
          dec.imm       = imm_u;
          dec.reg_write = full_mask;
        end
        OP_AUIPC: begin
          dec.rf_src    = 2'b00;
          dec.alu_src   = 1'b1;
          dec.imm       = in_pc + imm_u;
          dec.reg_write = full_mask;
        end
        OP_JAL: begin
          dec.jump      = 1'b1;
          dec.rf_src    = 2'b01;
          dec.imm       = imm_j;
          dec.reg_write = full_mask;
        end
        OP_JALR: begin
          dec.jump      = 1'b1;
          dec.rf_src    = 2'b01;
          dec.alu_src   = 1'b1;
          dec.imm       = imm_i;
          dec.reg_write = full_mask;
        end
        OP_BRANCH: begin
          dec.branch = 1'b1;
          dec.imm    = imm_b;
        end
        OP_LOAD: begin
          bad           = size_bad;
          dec.mem_read  = 1'b1;
          dec.rf_src    = 2'b10;
          dec.alu_src   = 1'b1;
          dec.imm       = imm_i;
          dec.reg_write = size_mask;
          dec.sign      = ~funct3[2];
        end
        OP_STORE: begin
          bad         = size_bad;
          dec.rf_src  = 2'b10;
          dec.alu_src = 1'b1;
          dec.imm     = imm_s;
          dec.we      = size_mask;
        end
        OP_OPIMM: begin
          dec.rf_src    = 2'b11;
          dec.alu_src   = 1'b1;
          dec.imm       = imm_i;
          dec.reg_write = full_mask;
        end
        OP_OP: begin
          bad           = (funct7 == 7'b0000001) && (ENABLE_M == 0);
          dec.rf_src    = 2'b11;
          dec.reg_write = full_mask;
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid && ~skid_vld_q && ~flush;
  assign drain    = ~out_vld_q || out_ready;

  // The skid entry is always older than anything at the input, so it refills first.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      out_d      = '0;
      skid_vld_d = 1'b0;
      skid_d     = '0;
    end else if (drain) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

  assign out_valid     = out_vld_q;
  assign out_pc        = out_q.pc;
  assign out_branch    = out_q.branch;
  assign out_jump      = out_q.jump;
  assign out_mem_read  = out_q.mem_read;
  assign out_rf_src    = out_q.rf_src;
  assign out_alu_src   = out_q.alu_src;
  assign out_we        = out_q.we;
  assign out_reg_write = out_q.reg_write;
  assign out_imm       = out_q.imm;
  assign out_sign      = out_q.sign;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a 32-bit/no-M and a 64-bit/M instance share one stimulus stream,
// each checked against a queue model of stage occupancy plus a rule-based decoder.
module tb_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic        branch;
    logic        jump;
    logic        mem_read;
    logic [1:0]  rf_src;
    logic        alu_src;
    logic [7:0]  we;
    logic [7:0]  rw;
    logic [63:0] imm;
    logic        sign;
    logic        illegal;
  } bnd_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [63:0] in_pc_w;

  logic        a_in_ready, a_out_valid, a_branch, a_jump, a_mem_read, a_alu_src, a_sign, a_illegal;
  logic [31:0] a_pc, a_imm;
  logic [1:0]  a_rf_src;
  logic [3:0]  a_we, a_rw;

  logic        b_in_ready, b_out_valid, b_branch, b_jump, b_mem_read, b_alu_src, b_sign, b_illegal;
  logic [63:0] b_pc, b_imm;
  logic [1:0]  b_rf_src;
  logic [7:0]  b_we, b_rw;

  int total = 0;
  int bad   = 0;
  bnd_t q32[$];
  bnd_t q64[$];

  assign in_pc_w = {32'b0, in_pc};

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ENABLE_M(0)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_branch(a_branch), .out_jump(a_jump), .out_mem_read(a_mem_read),
    .out_rf_src(a_rf_src), .out_alu_src(a_alu_src), .out_we(a_we), .out_reg_write(a_rw),
    .out_imm(a_imm), .out_sign(a_sign), .out_illegal(a_illegal)
  );

  decode_stage #(.XLEN(64), .ENABLE_M(1)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc_w), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_branch(b_branch), .out_jump(b_jump), .out_mem_read(b_mem_read),
    .out_rf_src(b_rf_src), .out_alu_src(b_alu_src), .out_we(b_we), .out_reg_write(b_rw),
    .out_imm(b_imm), .out_sign(b_sign), .out_illegal(b_illegal)
  );

  // Reference decoder written straight from the instruction-format rules.
  function automatic bnd_t ref_decode(logic [31:0] ins, logic [63:0] pc, int xlen, bit enm);
    bnd_t        b;
    logic [63:0] xm;
    logic [7:0]  full, smask;
    longint      i_imm, s_imm, b_imm, j_imm, u_imm;
    int          nbytes;
    bit          ill;
    xm     = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    full   = 8'((1 << (xlen / 8)) - 1);
    nbytes = 1 << ins[13:12];
    smask  = 8'((1 << nbytes) - 1);
    i_imm  = longint'($signed(ins[31:20]));
    s_imm  = longint'($signed({ins[31:25], ins[11:7]}));
    b_imm  = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    j_imm  = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    u_imm  = longint'($signed({ins[31:12], 12'b0}));
    b      = '0;
    ill    = 0;
    if (ins[1:0] != 2'b11) ill = 1;
    else case (ins[6:2])
      5'b01101: begin b.alu_src = 1; b.imm = u_imm; b.rw = full; end
      5'b00101: begin b.alu_src = 1; b.imm = pc + u_imm; b.rw = full; end
      5'b11011: begin b.jump = 1; b.rf_src = 1; b.imm = j_imm; b.rw = full; end
      5'b11001: begin b.jump = 1; b.rf_src = 1; b.alu_src = 1; b.imm = i_imm; b.rw = full; end
      5'b11000: begin b.branch = 1; b.imm = b_imm; end
      5'b00000: begin
        ill = (nbytes * 8 > xlen);
        b.mem_read = 1; b.rf_src = 2; b.alu_src = 1; b.imm = i_imm; b.rw = smask; b.sign = !ins[14];
      end
      5'b01000: begin
        ill = (nbytes * 8 > xlen);
        b.rf_src = 2; b.alu_src = 1; b.imm = s_imm; b.we = smask;
      end
      5'b00100: begin b.rf_src = 3; b.alu_src = 1; b.imm = i_imm; b.rw = full; end
      5'b01100: begin ill = (ins[31:25] == 7'd1) && !enm; b.rf_src = 3; b.rw = full; end
      default:  ill = 1;
    endcase
    if (ill) begin
      b = '0;
      b.illegal = 1;
    end
    b.pc  = pc & xm;
    b.imm = b.imm & xm;
    return b;
  endfunction

  function automatic bnd_t obs_a();
    bnd_t o;
    o = '{pc: {32'b0, a_pc}, branch: a_branch, jump: a_jump, mem_read: a_mem_read,
          rf_src: a_rf_src, alu_src: a_alu_src, we: {4'b0, a_we}, rw: {4'b0, a_rw},
          imm: {32'b0, a_imm}, sign: a_sign, illegal: a_illegal};
    return o;
  endfunction

  function automatic bnd_t obs_b();
    bnd_t o;
    o = '{pc: b_pc, branch: b_branch, jump: b_jump, mem_read: b_mem_read,
          rf_src: b_rf_src, alu_src: b_alu_src, we: b_we, rw: b_rw,
          imm: b_imm, sign: b_sign, illegal: b_illegal};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_out_valid", 256'(a_out_valid), 256'(q32.size() > 0));
    chk("a_in_ready",  256'(a_in_ready),  256'(q32.size() < 2));
    chk("b_out_valid", 256'(b_out_valid), 256'(q64.size() > 0));
    chk("b_in_ready",  256'(b_in_ready),  256'(q64.size() < 2));
    if (q32.size() > 0) chk("a_bundle", 256'(obs_a()), 256'(q32[0]));
    if (q64.size() > 0) chk("b_bundle", 256'(obs_b()), 256'(q64[0]));
  endtask

  // Drive one cycle of inputs, advance the model, then compare at the next falling edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic fl, input logic rs);
    bit acc;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    reset     = rs;
    if (rs || fl) begin
      q32.delete();
      q64.delete();
    end else begin
      acc = v && (q32.size() < 2);
      if (q32.size() > 0 && rdy) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (acc) begin
        q32.push_back(ref_decode(ins, {32'b0, pc}, 32, 0));
        q64.push_back(ref_decode(ins, {32'b0, pc}, 64, 1));
      end
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [4:0]  ops [9];
    int          sel;
    ops = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
            5'b00000, 5'b01000, 5'b00100, 5'b01100};
    r   = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 9) r[6:0] = {ops[sel], 2'b11};
    else if (sel == 10) r = {7'b0000001, r[24:7], 7'b0110011};
    return r;
  endfunction

  localparam logic [31:0] I_LUI   = 32'h12345037;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_SW    = 32'h00112223;
  localparam logic [31:0] I_SB    = 32'h00110223;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_LW    = 32'h0040A103;

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_bundle_a", 256'(obs_a()), 256'(0));
    chk("rst_bundle_b", 256'(obs_b()), 256'(0));

    cyc(1, I_LUI, 32'h40, 1, 0, 0);
    chk("lui_valid", 256'(a_out_valid), 256'(1));
    chk("lui_imm",   256'(a_imm),       256'(32'h12345000));
    chk("lui_rw",    256'(a_rw),        256'(4'hF));
    chk("lui_rfsrc", 256'(a_rf_src),    256'(2'b00));

    cyc(1, I_AUIPC, 32'h100, 1, 0, 0);
    chk("auipc_imm", 256'(a_imm), 256'(32'h00001100));
    cyc(1, I_AUIPC, 32'hFFFFF000, 1, 0, 0);
    chk("auipc_wrap", 256'(a_imm), 256'(32'h0));

    cyc(1, I_SW, 32'h200, 1, 0, 0);
    chk("sw_we",  256'(a_we),      256'(4'hF));
    chk("sw_imm", 256'(a_imm),     256'(32'h4));
    chk("sw_rw",  256'(a_rw),      256'(4'h0));
    chk("sw_alu", 256'(a_alu_src), 256'(1));
    cyc(1, I_SB, 32'h204, 1, 0, 0);
    chk("sb_we", 256'(a_we), 256'(4'h1));

    cyc(1, 32'h0, 32'h208, 1, 0, 0);
    chk("zero_illegal", 256'(a_illegal), 256'(1));
    chk("zero_masks",   256'({a_we, a_rw, a_branch, a_jump, a_mem_read}), 256'(0));
    cyc(1, I_MUL, 32'h20C, 1, 0, 0);
    chk("mul_noM_illegal", 256'(a_illegal), 256'(1));
    chk("mul_M_legal",     256'(b_illegal), 256'(0));
    cyc(0, 0, 0, 1, 0, 0);

    // Back-to-back with a two-cycle downstream stall.
    cyc(1, I_ADDI, 32'h300, 0, 0, 0);
    cyc(1, I_LW,   32'h304, 0, 0, 0);
    chk("stall_in_ready", 256'(a_in_ready), 256'(0));
    cyc(1, I_LUI,  32'h308, 0, 0, 0);
    chk("stall_hold_imm", 256'(a_imm), 256'(32'h5));
    cyc(1, I_LUI,  32'h308, 1, 0, 0);
    chk("second_out", 256'({a_mem_read, a_imm}), 256'({1'b1, 32'h4}));
    cyc(1, I_LUI,  32'h308, 1, 0, 0);
    chk("third_out", 256'(a_pc), 256'(32'h308));
    cyc(0, 0, 0, 1, 0, 0);

    // Flush, then reset, with both registers full and a same-cycle input.
    cyc(1, I_ADDI, 32'h400, 0, 0, 0);
    cyc(1, I_LW,   32'h404, 0, 0, 0);
    cyc(1, I_LUI,  32'h408, 1, 1, 0);
    chk("flush_valid", 256'(a_out_valid), 256'(0));
    chk("flush_ready", 256'(a_in_ready),  256'(1));
    cyc(0, 0, 0, 1, 0, 0);
    chk("flush_dropped", 256'(a_out_valid), 256'(0));
    cyc(1, I_ADDI, 32'h500, 0, 0, 0);
    cyc(1, I_LW,   32'h504, 0, 0, 0);
    cyc(1, I_LUI,  32'h508, 1, 1, 1);
    chk("reset_valid", 256'(a_out_valid), 256'(0));
    chk("reset_ready", 256'(a_in_ready),  256'(1));

    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 9) < 7, rnd_instr(), $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
